// File: rtl/reram_cmd_sequencer.sv
// reram_cmd_sequencer: Wishbone front end that queues ReRAM cell commands
// (READ/SET/RESET), issues them one at a time to the 32x32 array core over
// a req/ack handshake with timeout, and returns READ words through a
// read-data FIFO drained by software.
//
// Core handshake: core_req_o is high for the whole time a command is
// outstanding and op/row/col are stable while it is high. The core answers
// with a one-cycle core_ack_i pulse (core_rdata_i valid with it on READ).
// The command retires on the edge where req and ack are both high. An ack
// seen while req is low is ignored. core_req_o always shows at least one
// low cycle between two commands.
//
// Bus timing: a decoded strobe is acked on the next cycle. The register
// side effects (FIFO push/pop, sticky set/clear) take effect at the end of
// the ack cycle, and read data is driven combinationally during that cycle
// from the same state the side effect uses.
module reram_cmd_sequencer #(
  parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
  parameter int          CMD_DEPTH      = 8,
  parameter int          RD_DEPTH       = 4,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        core_req_o,
  output logic [1:0]  core_op_o,
  output logic [4:0]  core_row_o,
  output logic [4:0]  core_col_o,
  input  logic        core_ack_i,
  input  logic [31:0] core_rdata_i,
  output logic        dbg_state
);

  localparam int CA = $clog2(CMD_DEPTH);
  localparam int RA = $clog2(RD_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CA:0]   CMD_FULL_LVL = (CA+1)'(CMD_DEPTH);
  localparam logic [RA:0]   RD_FULL_LVL  = (RA+1)'(RD_DEPTH);
  localparam logic [CA:0]   CMD_ONE      = (CA+1)'(1);
  localparam logic [RA:0]   RD_ONE       = (RA+1)'(1);
  localparam logic [CA-1:0] CPTR_ONE     = CA'(1);
  localparam logic [RA-1:0] RPTR_ONE     = RA'(1);
  localparam logic [TW-1:0] T_LAST       = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE        = TW'(1);

  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RDATA  = 2'd2;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  // ---------------------------------------------------------------------
  // Wishbone front end
  // ---------------------------------------------------------------------
  logic        hit;
  logic        accept;
  logic        ack_q;
  logic        req_we;
  logic [1:0]  req_reg;
  logic [31:0] req_dat;

  assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign accept = hit & ~ack_q;

  // Ack one cycle after a decoded strobe, never two cycles in a row; latch the access.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      req_we  <= 1'b0;
      req_reg <= 2'd0;
      req_dat <= 32'd0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        req_we  <= wbs_we_i;
        req_reg <= wbs_adr_i[3:2];
        req_dat <= wbs_dat_i;
      end
    end
  end

  assign wbs_ack_o = ack_q;

  // ---------------------------------------------------------------------
  // Register side effects during the ack cycle
  // ---------------------------------------------------------------------
  logic       cmd_write;
  logic       cmd_valid_op;
  logic       cmd_push;
  logic       ovf_set;
  logic [2:0] stat_clr;
  logic       rd_read;
  logic       rd_pop;
  logic       udf_set;
  logic       cmd_empty;
  logic       cmd_full;
  logic       rd_empty;
  logic       rd_full;

  assign cmd_write    = ack_q & req_we & (req_reg == REG_CMD);
  assign cmd_valid_op = (req_dat[1:0] != 2'd0);
  // Full is the flag as it stood this cycle, so a same-cycle pop does not make room.
  assign cmd_push     = cmd_write & cmd_valid_op & ~cmd_full;
  assign ovf_set      = cmd_write & cmd_valid_op & cmd_full;
  assign stat_clr     = (ack_q & req_we & (req_reg == REG_STATUS)) ? req_dat[6:4] : 3'b000;
  assign rd_read      = ack_q & ~req_we & (req_reg == REG_RDATA);
  assign rd_pop       = rd_read & ~rd_empty;
  assign udf_set      = rd_read & rd_empty;

  // ---------------------------------------------------------------------
  // Command FIFO: entries are {op, row, col}
  // ---------------------------------------------------------------------
  logic [11:0]   cmd_mem [CMD_DEPTH];
  logic [CA-1:0] cmd_wptr;
  logic [CA-1:0] cmd_rptr;
  logic [CA:0]   cmd_level;
  logic          cmd_pop;
  logic [11:0]   cmd_head;

  assign cmd_empty = (cmd_level == '0);
  assign cmd_full  = (cmd_level == CMD_FULL_LVL);
  assign cmd_head  = cmd_mem[cmd_rptr];

  // Command storage write port (contents need no reset; level gates use).
  always_ff @(posedge wb_clk_i) begin
    if (cmd_push) begin
      cmd_mem[cmd_wptr] <= {req_dat[1:0], req_dat[12:8], req_dat[20:16]};
    end
  end

  // Command FIFO pointers and level.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_wptr  <= '0;
      cmd_rptr  <= '0;
      cmd_level <= '0;
    end else begin
      if (cmd_push) cmd_wptr <= cmd_wptr + CPTR_ONE;
      if (cmd_pop)  cmd_rptr <= cmd_rptr + CPTR_ONE;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_level <= cmd_level + CMD_ONE;
        2'b01:   cmd_level <= cmd_level - CMD_ONE;
        default: cmd_level <= cmd_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read-data FIFO
  // ---------------------------------------------------------------------
  logic [31:0]   rd_mem [RD_DEPTH];
  logic [RA-1:0] rd_wptr;
  logic [RA-1:0] rd_rptr;
  logic [RA:0]   rd_level;
  logic          rd_push;

  assign rd_empty = (rd_level == '0);
  assign rd_full  = (rd_level == RD_FULL_LVL);

  // Read-data storage write port.
  always_ff @(posedge wb_clk_i) begin
    if (rd_push) begin
      rd_mem[rd_wptr] <= core_rdata_i;
    end
  end

  // Read-data FIFO pointers and level; push and pop together keep the level.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_wptr  <= '0;
      rd_rptr  <= '0;
      rd_level <= '0;
    end else begin
      if (rd_push) rd_wptr <= rd_wptr + RPTR_ONE;
      if (rd_pop)  rd_rptr <= rd_rptr + RPTR_ONE;
      case ({rd_push, rd_pop})
        2'b10:   rd_level <= rd_level + RD_ONE;
        2'b01:   rd_level <= rd_level - RD_ONE;
        default: rd_level <= rd_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------
  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [TW-1:0] tcnt_q;
  logic          tmo_set;

  // Next-state logic: a head READ waits for room in the read-data FIFO so
  // its result can never be lost.
  always_comb begin
    state_d = state_q;
    cmd_pop = 1'b0;
    rd_push = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!cmd_empty && !((cmd_head[11:10] == OP_READ) && rd_full)) begin
          state_d = S_ISSUE;
          cmd_pop = 1'b1;
        end
      end
      S_ISSUE: begin
        if (core_ack_i) begin
          state_d = S_IDLE;
          rd_push = (core_op_o == OP_READ) & ~rd_full;
        end else if (tcnt_q == T_LAST) begin
          state_d = S_IDLE;
          tmo_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, timeout counter and the registered core command fields.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      tcnt_q     <= '0;
      core_op_o  <= 2'd0;
      core_row_o <= 5'd0;
      core_col_o <= 5'd0;
    end else begin
      state_q <= state_d;
      if (cmd_pop) begin
        tcnt_q     <= '0;
        core_op_o  <= cmd_head[11:10];
        core_row_o <= cmd_head[9:5];
        core_col_o <= cmd_head[4:0];
      end else if (state_q == S_ISSUE) begin
        tcnt_q <= tcnt_q + T_ONE;
      end
    end
  end

  assign core_req_o = (state_q == S_ISSUE);
  assign dbg_state  = state_q;

  // ---------------------------------------------------------------------
  // Sticky status bits: a same-cycle set wins over a software clear
  // ---------------------------------------------------------------------
  logic ovf_q;
  logic tmo_q;
  logic udf_q;

  // Overflow, timeout and underflow flags.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~stat_clr[0]);
      tmo_q <= tmo_set | (tmo_q & ~stat_clr[1]);
      udf_q <= udf_set | (udf_q & ~stat_clr[2]);
    end
  end

  // ---------------------------------------------------------------------
  // Read data mux, driven only while a read is being acked
  // ---------------------------------------------------------------------
  logic [31:0] status_word;
  logic [31:0] reg_word;

  assign status_word = {20'd0, 4'(cmd_level), 1'b0, udf_q, tmo_q, ovf_q,
                        ~rd_empty, (state_q != S_IDLE), cmd_full, cmd_empty};

  // Register selection for reads; CMD and the spare slot read as zero.
  always_comb begin
    reg_word = 32'd0;
    case (req_reg)
      REG_STATUS: reg_word = status_word;
      REG_RDATA:  reg_word = rd_empty ? 32'd0 : rd_mem[rd_rptr];
      default:    reg_word = 32'd0;
    endcase
  end

  assign wbs_dat_o = (ack_q & ~req_we) ? reg_word : 32'd0;

  // Bits that carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], req_dat[31:21],
                         req_dat[15:13], req_dat[7], req_dat[3:2]};

endmodule

// File: tb/tb_reram_cmd_sequencer.sv
// Directed bench for reram_cmd_sequencer with a behavioural array-core
// responder and an expected queue for READ results.
module tb_reram_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = 32'd0;
  logic [31:0] dat = 32'd0;
  logic        wbs_ack;
  logic [31:0] wbs_dat;
  logic        core_req;
  logic [1:0]  core_op;
  logic [4:0]  core_row;
  logic [4:0]  core_col;
  logic        core_ack   = 1'b0;
  logic [31:0] core_rdata = 32'd0;
  logic        dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q[$];

  // responder controls (written by the main sequence only)
  int          ack_delay = 0;
  logic [31:0] rdata_base = 32'd0;
  int          late_req = 0;
  // responder state (written by the responder only)
  int late_done = 0;
  int wait_cnt  = 0;
  int run       = 0;
  int last_run  = 0;
  int last_lat  = 0;

  // clock
  always #5 clk = ~clk;

  reram_cmd_sequencer #(
    .BASE_ADR(32'h3000_0000), .CMD_DEPTH(8), .RD_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(wbs_ack), .wbs_dat_o(wbs_dat),
    .core_req_o(core_req), .core_op_o(core_op), .core_row_o(core_row),
    .core_col_o(core_col), .core_ack_i(core_ack), .core_rdata_i(core_rdata),
    .dbg_state(dbg_state)
  );

  // array-core model: acks ack_delay cycles into a request (0 = never),
  // can emit a stray ack on demand, and measures request length
  always @(negedge clk) begin
    core_ack = 1'b0;
    if (late_req != late_done) begin
      core_ack   = 1'b1;
      core_rdata = 32'hDEAD_BEEF;
      late_done  = late_req;
    end else if (core_req && ack_delay != 0) begin
      wait_cnt = wait_cnt + 1;
      if (wait_cnt == ack_delay) begin
        core_ack   = 1'b1;
        core_rdata = rdata_base + 32'(core_row);
      end
    end
    if (!core_req) wait_cnt = 0;
    if (core_req) run = run + 1;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [3:0] off, input logic [31:0] d,
                         output logic [31:0] rd);
    int lat;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = 32'h3000_0000 | {28'd0, off}; dat = d;
    lat = 0;
    rd  = 32'd0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (wbs_ack) break;
    end
    check_eq("wb_ack_seen", {31'd0, wbs_ack}, 32'd1);
    rd = wbs_dat;
    last_lat = lat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] unused_rd;
    wb_xfer(1'b1, off, d, unused_rd);
  endtask

  task automatic wb_read(input logic [3:0] off, output logic [31:0] d);
    wb_xfer(1'b0, off, 32'd0, d);
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] v;
    wb_read(4'h4, v);
    check_eq(tag, v, exp);
  endtask

  task automatic check_rdata(input string tag);
    logic [31:0] v;
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd0;
    wb_read(4'h8, v);
    check_eq(tag, v, e);
  endtask

  task automatic wait_req(input logic lvl, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (core_req == lvl) break;
    end
    check_eq(tag, {31'd0, core_req}, {31'd0, lvl});
  endtask

  task automatic write_read_cmd(input int row);
    wb_write(4'h0, 32'((row & 31) << 8) | 32'h1);
    exp_q.push_back(rdata_base + 32'(row & 31));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int acks;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", {31'd0, wbs_ack}, 32'd0);
    check_eq("rst_dat", wbs_dat, 32'd0);
    check_eq("rst_req", {31'd0, core_req}, 32'd0);
    check_eq("rst_core_fields", {20'd0, core_op, core_row, core_col}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_status("rst_status", 32'h0000_0001);

    // undecoded address is never acked
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wbs_ack) acks++;
    end
    check_eq("undecoded_acks", 32'(acks), 32'd0);
    // held strobe on STATUS: acked every other cycle
    adr = 32'h3000_0004;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wbs_ack) acks++;
    end
    check_eq("held_stb_acks", 32'(acks), 32'd2);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);

    // SET row 5 col 3, core acks after 4 cycles
    ack_delay = 4;
    wb_write(4'h0, 32'h0003_0502);
    check_eq("cmd_ack_latency", 32'(last_lat), 32'd1);
    @(posedge clk); #1;
    check_eq("ack_single_cycle", {31'd0, wbs_ack}, 32'd0);
    check_eq("req_low_n1", {31'd0, core_req}, 32'd0);
    @(posedge clk); #1;
    check_eq("req_high_n2", {31'd0, core_req}, 32'd1);
    check_eq("set_fields", {20'd0, core_op, core_row, core_col}, 32'h0000_08A3);
    wait_req(1'b0, 20, "set_done");
    @(negedge clk); #1;
    check_eq("set_req_len", 32'(last_run), 32'd4);
    check_status("set_status", 32'h0000_0001);

    // op=0 is dropped, CMD and spare slot read zero
    wb_write(4'h0, 32'h0000_0500);
    repeat (3) @(posedge clk);
    #1;
    check_eq("op0_no_req", {31'd0, core_req}, 32'd0);
    check_status("op0_status", 32'h0000_0001);
    wb_read(4'h0, v);
    check_eq("cmd_reads_zero", v, 32'd0);
    wb_read(4'hC, v);
    check_eq("spare_reads_zero", v, 32'd0);

    // READ row 7, drain, underflow
    rdata_base = 32'hA5A5_1200;
    write_read_cmd(7);
    wait_req(1'b1, 10, "read_req");
    wait_req(1'b0, 20, "read_done");
    check_status("read_avail", 32'h0000_0009);
    check_rdata("rdata_row7");
    check_status("read_drained", 32'h0000_0001);
    wb_read(4'h8, v);
    check_eq("rdata_empty", v, 32'd0);
    check_status("udf_set", 32'h0000_0041);
    wb_write(4'h4, 32'h0000_0040);
    check_status("udf_clear", 32'h0000_0001);

    // timeout: READ row 3 never acked, then a SET
    ack_delay = 0;
    wb_write(4'h0, 32'h0000_0301);
    wb_write(4'h0, 32'h0001_0102);
    check_status("issue_status", 32'h0000_0104);
    wait_req(1'b0, 40, "tmo_drop");
    ack_delay = 2;
    @(posedge clk); #1;
    check_eq("next_issue_after_gap", {31'd0, core_req}, 32'd1);
    check_eq("tmo_req_len", 32'(last_run), 32'd16);
    check_eq("tmo_next_fields", {20'd0, core_op, core_row, core_col}, 32'h0000_0821);
    wait_req(1'b0, 20, "tmo_next_done");
    check_status("tmo_status", 32'h0000_0021);
    late_req = late_req + 1;
    repeat (3) @(posedge clk);
    check_status("late_ack_ignored", 32'h0000_0021);
    wb_write(4'h4, 32'h0000_0020);
    check_status("tmo_clear", 32'h0000_0001);

    // read-data FIFO back-pressure and command overflow
    ack_delay  = 2;
    rdata_base = 32'h5000_0000;
    for (int i = 0; i < 5; i++) write_read_cmd(10 + i);
    repeat (40) @(posedge clk);
    #1;
    check_eq("stall_req_low", {31'd0, core_req}, 32'd0);
    check_status("stall_status", 32'h0000_0108);
    for (int i = 0; i < 7; i++) wb_write(4'h0, 32'h0001_0002 | 32'(i << 8));
    check_status("cmd_full_status", 32'h0000_080A);
    wb_write(4'h0, 32'h0001_1F03);
    check_status("ovf_status", 32'h0000_081A);
    check_eq("ovf_req_low", {31'd0, core_req}, 32'd0);
    wb_write(4'h4, 32'h0000_0010);
    check_status("ovf_clear", 32'h0000_080A);
    check_rdata("rdata_row10");
    wait_req(1'b1, 10, "stalled_read_issue");
    check_eq("stalled_read_fields", {20'd0, core_op, core_row, core_col}, 32'h0000_05C0);
    wait_req(1'b0, 10, "stalled_read_done");
    for (int i = 0; i < 4; i++) check_rdata("rdata_drain");
    repeat (60) @(posedge clk);
    check_status("drain_status", 32'h0000_0001);

    // reset while a command is outstanding with 3 queued
    ack_delay = 0;
    for (int i = 0; i < 4; i++) wb_write(4'h0, 32'h0002_0003 | 32'(i << 8));
    check_status("pre_reset_status", 32'h0000_0304);
    check_eq("pre_reset_req", {31'd0, core_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("reset_drops_req", {31'd0, core_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_status("post_reset_status", 32'h0000_0001);
    repeat (5) @(posedge clk);
    #1;
    check_eq("post_reset_idle", {31'd0, core_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
